// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - write sources and register-file write port bundle
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_waddr;
    logic [DATA_W-1:0] mc_wdata;
    logic              mc_ready;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output mc_valid, mc_waddr, mc_wdata,
        input  mc_ready,
        input  rf_write_enable, rf_write_addr, rf_write_data
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  mc_valid, mc_waddr, mc_wdata,
        output mc_ready,
        output rf_write_enable, rf_write_addr, rf_write_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter; optional WAW_SQUASH_EN
module regfile_write_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BUF_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    regfile_write_arbiter_if.slave         bus,
    input  logic [ADDR_W-1:0]              chk_addr1,
    input  logic [ADDR_W-1:0]              chk_addr2,
    output logic                           busy1,
    output logic                           busy2,
    output logic [$clog2(BUF_DEPTH):0]     buf_count
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]    addr_mem_q [BUF_DEPTH];
    logic [DATA_W-1:0]    data_mem_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 wen_q, wen_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic pipe_req, full, empty, push, pop;

    // A pipe write to r0 is treated as no request at all.
    assign pipe_req = bus.pipe_we && (bus.pipe_waddr != '0);
    assign full     = (count_q == CNT_W'(BUF_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = bus.mc_valid && !full;
    assign pop      = !pipe_req && !empty;

    assign bus.mc_ready        = !full;
    assign bus.rf_write_enable = wen_q;
    assign bus.rf_write_addr   = waddr_q;
    assign bus.rf_write_data   = wdata_q;
    assign buf_count           = count_q;

    // Issue select: pipe wins, else the FIFO head (dead heads drain silently).
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pipe_req) begin
            wen_d   = 1'b1;
            waddr_d = bus.pipe_waddr;
            wdata_d = bus.pipe_wdata;
        end else if (pop && live_q[head_q]) begin
            wen_d   = 1'b1;
            waddr_d = addr_mem_q[head_q];
            wdata_d = data_mem_q[head_q];
        end
    end

    // FIFO pointers, occupancy and per-entry live bits.
    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        live_d = live_q;
        if (pop) begin
            live_d[head_q] = 1'b0;
        end
`ifdef WAW_SQUASH_EN
        // A younger pipe write kills every queued older write to the same register.
        if (pipe_req) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (addr_mem_q[i] == bus.pipe_waddr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
`endif
        if (push) begin
            live_d[tail_q] = (bus.mc_waddr != '0);
`ifdef WAW_SQUASH_EN
            if (pipe_req && (bus.mc_waddr == bus.pipe_waddr)) begin
                live_d[tail_q] = 1'b0;
            end
`endif
        end
    end

    // Pending-write hazard lookup over live entries and the output register.
    always_comb begin
        busy1 = wen_q && (waddr_q == chk_addr1);
        busy2 = wen_q && (waddr_q == chk_addr2);
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (live_q[i] && (addr_mem_q[i] == chk_addr1)) busy1 = 1'b1;
            if (live_q[i] && (addr_mem_q[i] == chk_addr2)) busy2 = 1'b1;
        end
        if (chk_addr1 == '0) busy1 = 1'b0;
        if (chk_addr2 == '0) busy2 = 1'b0;
    end

    // Control state and output register; reset discards all queued writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // FIFO payload storage; validity is carried entirely by live_q and count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[tail_q] <= bus.mc_waddr;
            data_mem_q[tail_q] <= bus.mc_wdata;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed table and sequence bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
`ifdef WAW_SQUASH_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] chk_addr1, chk_addr2;
    logic       busy1, busy2;
    logic [2:0] buf_count;

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .BUF_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .busy1     (busy1),
        .busy2     (busy2),
        .buf_count (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct {
        logic pwe; logic [4:0] pa; logic [31:0] pd;
        logic mv;  logic [4:0] ma; logic [31:0] md;
        logic [4:0] c1; logic [4:0] c2;
        logic e_rdy; logic e_en; logic [4:0] e_addr; logic [31:0] e_data;
        logic e_b1; logic e_b2; int e_cnt;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [36:0] q[$];
    int maxc = 0;
    int commits = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic [4:0] c1, input logic [4:0] c2,
                                input logic e_rdy, input logic e_en, input logic [4:0] e_addr,
                                input logic [31:0] e_data, input logic e_b1, input logic e_b2,
                                input int e_cnt);
        vec_t v;
        v.pwe = pwe; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md;
        v.c1 = c1; v.c2 = c2; v.e_rdy = e_rdy; v.e_en = e_en; v.e_addr = e_addr;
        v.e_data = e_data; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.pipe_we = pwe; bus.pipe_waddr = pa; bus.pipe_wdata = pd;
        bus.mc_valid = mv; bus.mc_waddr = ma; bus.mc_wdata = md;
    endtask

    // One cycle against a small FIFO model (all addresses nonzero, no squash conflicts).
    task automatic mstep(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         output logic acc);
        logic        exp_rdy, has_pop, pipe;
        logic [36:0] popped;
        @(negedge clk);
        drive(pwe, pa, pd, mv, ma, md);
        exp_rdy = (q.size() < 4);
        chk("mc_ready", 32'(bus.mc_ready), 32'(exp_rdy));
        chk("buf_count", 32'(buf_count), 32'(q.size()));
        pipe    = pwe && (pa != 5'd0);
        has_pop = !pipe && (q.size() > 0);
        popped  = '0;
        if (has_pop) popped = q.pop_front();
        acc = mv && exp_rdy;
        if (acc) q.push_back({ma, md});
        @(posedge clk);
        #1;
        if (int'(buf_count) > maxc) maxc = int'(buf_count);
        chk("rf_we", 32'(bus.rf_write_enable), 32'(pipe || has_pop));
        if (pipe) begin
            chk("rf_addr_pipe", 32'(bus.rf_write_addr), 32'(pa));
            chk("rf_data_pipe", bus.rf_write_data, pd);
        end else if (has_pop) begin
            commits++;
            chk("rf_addr_mc", 32'(bus.rf_write_addr), 32'(popped[36:32]));
            chk("rf_data_mc", bus.rf_write_data, popped[31:0]);
        end
    endtask

    vec_t tbl[18];

    initial begin
        logic acc;
        int   idx;
        tbl[0]  = mk(1, 5, 32'h11, 1, 7, 32'h22, 7, 5,  1, 1, 5, 32'h11, 1, 1, 1);
        tbl[1]  = mk(1, 5, 32'h11, 0, 0, 0,      7, 0,  1, 1, 5, 32'h11, 1, 0, 1);
        tbl[2]  = mk(1, 5, 32'h11, 0, 0, 0,      7, 5,  1, 1, 5, 32'h11, 1, 1, 1);
        tbl[3]  = mk(0, 0, 0,      0, 0, 0,      7, 5,  1, 1, 7, 32'h22, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0,      0, 0, 0,      7, 0,  1, 0, 7, 32'h22, 0, 0, 0);
        tbl[5]  = mk(1, 0, 32'h33, 1, 0, 32'h44, 0, 0,  1, 0, 7, 32'h22, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 0, 7, 32'h22, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  1, 0, 7, 32'h22, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0,      1, 9, 32'hAB, 9, 9,  1, 0, 7, 32'h22, 1, 1, 1);
        tbl[9]  = mk(0, 0, 0,      0, 0, 0,      9, 0,  1, 1, 9, 32'hAB, 1, 0, 0);
        tbl[10] = mk(0, 0, 0,      0, 0, 0,      9, 0,  1, 0, 9, 32'hAB, 0, 0, 0);
        tbl[11] = mk(0, 0, 0,      1, 3, 32'hAA, 3, 0,  1, 0, 9, 32'hAB, 1, 0, 1);
        tbl[12] = mk(1, 3, 32'hBB, 0, 0, 0,      3, 0,  1, 1, 3, 32'hBB, 1, 0, 1);
        tbl[13] = mk(0, 0, 0,      0, 0, 0,      3, 0,  1, !SQ, 3, SQ ? 32'hBB : 32'hAA, !SQ, 0, 0);
        tbl[14] = mk(0, 0, 0,      0, 0, 0,      3, 0,  1, 0, 3, SQ ? 32'hBB : 32'hAA, 0, 0, 0);
        tbl[15] = mk(1, 6, 32'hC1, 1, 6, 32'hC2, 6, 0,  1, 1, 6, 32'hC1, 1, 0, 1);
        tbl[16] = mk(0, 0, 0,      0, 0, 0,      6, 0,  1, !SQ, 6, SQ ? 32'hC1 : 32'hC2, !SQ, 0, 0);
        tbl[17] = mk(0, 0, 0,      0, 0, 0,      6, 0,  1, 0, 6, SQ ? 32'hC1 : 32'hC2, 0, 0, 0);

        rst_n = 1'b0;
        chk_addr1 = '0;
        chk_addr2 = '0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_we", 32'(bus.rf_write_enable), 32'd0);
        chk("reset_addr", 32'(bus.rf_write_addr), 32'd0);
        chk("reset_data", bus.rf_write_data, 32'd0);
        chk("reset_count", 32'(buf_count), 32'd0);
        chk("reset_ready", 32'(bus.mc_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Priority, zero register, hazard and WAW vectors.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md);
            chk_addr1 = tbl[i].c1;
            chk_addr2 = tbl[i].c2;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.mc_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_we", i), 32'(bus.rf_write_enable), 32'(tbl[i].e_en));
            chk($sformatf("v%0d_addr", i), 32'(bus.rf_write_addr), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d_data", i), bus.rf_write_data, tbl[i].e_data);
            chk($sformatf("v%0d_busy1", i), 32'(busy1), 32'(tbl[i].e_b1));
            chk($sformatf("v%0d_busy2", i), 32'(busy2), 32'(tbl[i].e_b2));
            chk($sformatf("v%0d_count", i), 32'(buf_count), 32'(tbl[i].e_cnt));
        end
        chk_addr1 = '0;
        chk_addr2 = '0;

        // Full and wrap: fill under a stalled pipe, then drain with an interleaved stream.
        q.delete();
        idx = 1;
        for (int c = 0; c < 5; c++) begin
            mstep(1, 5'd20, 32'h500 + 32'(c), 1, 5'(idx), 32'h1000 + 32'(idx), acc);
            if (acc) idx++;
        end
        chk("fill_accepted", 32'(idx), 32'd5);
        chk("full_ready", 32'(bus.mc_ready), 32'd0);
        chk("full_count", 32'(buf_count), 32'd4);
        for (int c = 0; c < 40 && (idx <= 10 || q.size() > 0); c++) begin
            mstep(0, 0, 0, (c % 3 != 2) && (idx <= 10), 5'(idx), 32'h1000 + 32'(idx), acc);
            if (acc) idx++;
        end
        chk("wrap_commits", 32'(commits), 32'd10);
        chk("wrap_max_count", 32'(maxc), 32'd4);
        chk("wrap_drained", 32'(q.size()), 32'd0);

        // Asynchronous reset with three writes queued behind a stalled pipe.
        for (int c = 0; c < 3; c++) begin
            mstep(1, 5'd20, 32'h600, 1, 5'(11 + c), 32'h2000 + 32'(c), acc);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_count", 32'(buf_count), 32'd0);
        chk("midreset_we", 32'(bus.rf_write_enable), 32'd0);
        chk("midreset_ready", 32'(bus.mc_ready), 32'd1);
        chk("midreset_addr", 32'(bus.rf_write_addr), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mstep(0, 0, 0, 0, 0, 0, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
